// File: rtl/pending_priority_encoder_if.sv
// Request/withdraw inputs and the one-at-a-time valid/ready output channel
// of the pending priority encoder.
interface pending_priority_encoder_if #(
  parameter int N = 8
) ();
  localparam int W = $clog2(N);

  logic [N-1:0] req;
  logic [N-1:0] clr;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic         out_ready;
  logic [N-1:0] pending;
  logic [W:0]   pend_cnt;

  modport master (
    input  req, clr, out_ready,
    output out_valid, out_idx, pending, pend_cnt
  );

  modport slave (
    output req, clr, out_ready,
    input  out_valid, out_idx, pending, pend_cnt
  );
endinterface

// File: rtl/pending_priority_encoder.sv
// Sticky pending register feeding a registered valid/ready index presenter,
// fixed-priority (highest index wins) or round-robin.
module pending_priority_encoder #(
  parameter int N       = 8,
  parameter int RR_MODE = 0
) (
  input logic                        clk,
  input logic                        rst,
  pending_priority_encoder_if.master bus
);
  localparam int W = $clog2(N);
  localparam logic [W-1:0] TOP_IDX = W'(N - 1);

  if (N < 2 || N > 64) begin : g_bad_n
    $error("pending_priority_encoder: N must be in 2..64");
  end

  function automatic logic [W:0] popcount(input logic [N-1:0] v);
    logic [W:0] c;
    c = {(W+1){1'b0}};
    for (int i = 0; i < N; i++) begin
      c = c + {{W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  logic [N-1:0] pending_r;
  logic [W:0]   pend_cnt_r;
  logic         out_valid_r;
  logic [W-1:0] out_idx_r;
  logic [W-1:0] rr_top_r;

  logic [N-1:0] pending_next_s;
  logic         xfer_s;
  logic         clr_hit_s;
  logic         load_s;
  logic [W-1:0] rr_top_next_s;
  logic         sel_valid_s;
  logic [W-1:0] sel_idx_s;

  assign xfer_s = out_valid_r & bus.out_ready;
  assign load_s = ~out_valid_r | xfer_s | clr_hit_s;

  // Per-bit pending update: clr beats req, req beats the grant clear.
  always_comb begin
    pending_next_s = pending_r;
    for (int i = 0; i < N; i++) begin
      if (bus.clr[i]) begin
        pending_next_s[i] = 1'b0;
      end else if (bus.req[i]) begin
        pending_next_s[i] = 1'b1;
      end else if (xfer_s && (out_idx_r == W'(i))) begin
        pending_next_s[i] = 1'b0;
      end else begin
        pending_next_s[i] = pending_r[i];
      end
    end
  end

  // A withdraw of the presented index forces a reload even while stalled.
  always_comb begin
    clr_hit_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.clr[i] && (out_idx_r == W'(i))) begin
        clr_hit_s = out_valid_r;
      end else begin
        clr_hit_s = clr_hit_s;
      end
    end
  end

  // Round-robin pointer moves just below the index being transferred.
  always_comb begin
    if ((RR_MODE != 0) && xfer_s) begin
      rr_top_next_s = (out_idx_r == {W{1'b0}}) ? TOP_IDX : (out_idx_r - W'(1));
    end else begin
      rr_top_next_s = rr_top_r;
    end
  end

  // Selection over the post-update vector; later loop hits win.
  always_comb begin
    int cand;
    sel_valid_s = 1'b0;
    sel_idx_s   = {W{1'b0}};
    cand        = 0;
    if (RR_MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (pending_next_s[i]) begin
          sel_valid_s = 1'b1;
          sel_idx_s   = W'(i);
        end else begin
          sel_valid_s = sel_valid_s;
        end
      end
    end else begin
      // Walk distances far-to-near so the bit closest below rr_top wins.
      for (int d = N - 1; d >= 0; d--) begin
        cand = int'(rr_top_next_s) - d;
        if (cand < 0) begin
          cand = cand + N;
        end else begin
          cand = cand;
        end
        if (pending_next_s[cand]) begin
          sel_valid_s = 1'b1;
          sel_idx_s   = W'(cand);
        end else begin
          sel_valid_s = sel_valid_s;
        end
      end
    end
  end

  // State registers; the presented index is held through a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r   <= {N{1'b0}};
      pend_cnt_r  <= {(W+1){1'b0}};
      out_valid_r <= 1'b0;
      out_idx_r   <= {W{1'b0}};
      rr_top_r    <= TOP_IDX;
    end else begin
      pending_r  <= pending_next_s;
      pend_cnt_r <= popcount(pending_next_s);
      rr_top_r   <= rr_top_next_s;
      if (load_s) begin
        out_valid_r <= sel_valid_s;
        out_idx_r   <= sel_idx_s;
      end else begin
        out_valid_r <= out_valid_r;
        out_idx_r   <= out_idx_r;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_idx   = out_idx_r;
  assign bus.pending   = pending_r;
  assign bus.pend_cnt  = pend_cnt_r;
endmodule

// File: tb/tb_pending_priority_encoder.sv
// Bench for pending_priority_encoder: six configurations (N = 8, 5, 64 in both
// modes) against a queue-based reference model plus directed literal checks.
module tb_pending_priority_encoder;
  localparam int NCFG = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] req_a   [NCFG];
  logic [63:0] clr_a   [NCFG];
  logic        ready_a [NCFG];
  logic        ov_a    [NCFG];
  logic [31:0] oi_a    [NCFG];
  logic [63:0] pd_a    [NCFG];
  logic [31:0] pc_a    [NCFG];

  int tests = 0;
  int fails = 0;
  int fail_prints = 0;
  bit chk_en = 1'b0;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int NN = (g < 2) ? 8 : ((g < 4) ? 5 : 64);
    localparam int RR = g % 2;
    pending_priority_encoder_if #(.N(NN)) bus_i ();
    pending_priority_encoder #(.N(NN), .RR_MODE(RR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_i.master)
    );
    assign bus_i.req       = req_a[g][NN-1:0];
    assign bus_i.clr       = clr_a[g][NN-1:0];
    assign bus_i.out_ready = ready_a[g];
    assign ov_a[g] = bus_i.out_valid;
    assign oi_a[g] = 32'(bus_i.out_idx);
    assign pd_a[g] = 64'(bus_i.pending);
    assign pc_a[g] = 32'(bus_i.pend_cnt);
  end

  function automatic int cfg_n(input int c);
    return (c < 2) ? 8 : ((c < 4) ? 5 : 64);
  endfunction

  function automatic int cfg_rr(input int c);
    return c % 2;
  endfunction

  // Reference model state
  logic [63:0] m_pend  [NCFG];
  bit          m_valid [NCFG];
  int          m_idx   [NCFG];
  int          m_rr    [NCFG];

  task automatic note_fail(input string msg);
    fails++;
    if (fail_prints < 40) begin
      $display("FAIL %s", msg);
      fail_prints++;
    end
  endtask

  task automatic model_step(input int c);
    int n;
    bit rr;
    bit xfer;
    bit hit;
    bit found;
    int sel;
    logic [63:0] nxt;
    int order[$];
    n = cfg_n(c);
    rr = (cfg_rr(c) != 0);
    if (rst) begin
      m_pend[c] = 64'd0;
      m_valid[c] = 1'b0;
      m_idx[c] = 0;
      m_rr[c] = n - 1;
      return;
    end
    xfer = m_valid[c] && ready_a[c];
    nxt = m_pend[c];
    for (int i = 0; i < n; i++) begin
      if (clr_a[c][i]) nxt[i] = 1'b0;
      else if (req_a[c][i]) nxt[i] = 1'b1;
      else if (xfer && m_idx[c] == i) nxt[i] = 1'b0;
    end
    if (rr && xfer) m_rr[c] = (m_idx[c] == 0) ? n - 1 : m_idx[c] - 1;
    if (!rr) begin
      for (int i = n - 1; i >= 0; i--) order.push_back(i);
    end else begin
      for (int d = 0; d < n; d++) order.push_back((m_rr[c] - d + n) % n);
    end
    found = 1'b0;
    sel = 0;
    foreach (order[k]) begin
      if (!found && nxt[order[k]]) begin
        found = 1'b1;
        sel = order[k];
      end
    end
    hit = m_valid[c] && clr_a[c][m_idx[c]];
    if (!m_valid[c] || xfer || hit) begin
      m_valid[c] = found;
      m_idx[c] = sel;
    end
    m_pend[c] = nxt;
  endtask

  // Model advances on each edge; DUT compared just after it
  initial begin
    forever begin
      @(posedge clk);
      for (int c = 0; c < NCFG; c++) model_step(c);
      #1;
      if (chk_en) begin
        for (int c = 0; c < NCFG; c++) begin
          int cnt;
          cnt = $countones(m_pend[c]);
          tests++;
          if (ov_a[c] !== m_valid[c] || oi_a[c] !== 32'(m_idx[c]) ||
              pd_a[c] !== m_pend[c] || pc_a[c] !== 32'(cnt)) begin
            note_fail($sformatf("model_cmp cfg%0d t=%0t: got v=%0b idx=%0d pend=%h cnt=%0d, expected v=%0b idx=%0d pend=%h cnt=%0d",
              c, $time, ov_a[c], oi_a[c], pd_a[c], pc_a[c], m_valid[c], m_idx[c], m_pend[c], cnt));
          end
        end
      end
    end
  end

  // Handshake properties: accepted index pending, round-robin wait bound
  int wt [NCFG][64];
  initial begin
    for (int c = 0; c < NCFG; c++) for (int i = 0; i < 64; i++) wt[c][i] = 0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCFG; c++) begin
        int n;
        n = cfg_n(c);
        for (int i = 0; i < n; i++) if (pd_a[c][i] !== 1'b1) wt[c][i] = 0;
        if (chk_en && !rst && ov_a[c] === 1'b1 && ready_a[c]) begin
          tests++;
          if (pd_a[c][oi_a[c]] !== 1'b1)
            note_fail($sformatf("accept_not_pending cfg%0d t=%0t: idx=%0d pend=%h, expected bit set", c, $time, oi_a[c], pd_a[c]));
          if (cfg_rr(c) != 0) begin
            int worst;
            worst = 0;
            for (int i = 0; i < n; i++) begin
              if (i == int'(oi_a[c])) wt[c][i] = 0;
              else if (pd_a[c][i] === 1'b1) wt[c][i]++;
              if (wt[c][i] > worst) worst = wt[c][i];
            end
            tests++;
            if (worst > n)
              note_fail($sformatf("rr_starvation cfg%0d t=%0t: wait=%0d, expected <= %0d", c, $time, worst, n));
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) note_fail($sformatf("%s: got %0h, expected %0h", name, act, exp));
  endtask

  task automatic drive(input logic [63:0] r, input logic [63:0] cl, input logic rd);
    for (int c = 0; c < NCFG; c++) begin
      req_a[c] = r;
      clr_a[c] = cl;
      ready_a[c] = rd;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int rr_exp [6] = '{7, 1, 0, 7, 1, 0};
  logic [63:0] hold_a [NCFG];

  initial begin
    rst = 1'b1;
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
    tick();
    chk_en = 1'b1;
    check("rst_pending", pd_a[0], 64'd0);
    check("rst_valid", 64'(ov_a[0]), 64'd0);
    check("rst_idx", 64'(oi_a[0]), 64'd0);
    check("rst_cnt", 64'(pc_a[0]), 64'd0);

    rst = 1'b0;
    drive(64'd0, 64'd0, 1'b0);
    tick();
    // Fixed priority drain of a one-cycle pulse
    drive(64'hA4, 64'd0, 1'b1);
    tick();
    check("fp_idx0", 64'(oi_a[0]), 64'd7);
    check("fp_cnt0", 64'(pc_a[0]), 64'd3);
    drive(64'd0, 64'd0, 1'b1);
    tick();
    check("fp_idx1", 64'(oi_a[0]), 64'd5);
    check("fp_cnt1", 64'(pc_a[0]), 64'd2);
    tick();
    check("fp_idx2", 64'(oi_a[0]), 64'd2);
    check("fp_cnt2", 64'(pc_a[0]), 64'd1);
    tick();
    check("fp_valid3", 64'(ov_a[0]), 64'd0);
    check("fp_cnt3", 64'(pc_a[0]), 64'd0);

    // Stall: a higher request does not preempt the presented index
    drive(64'h08, 64'd0, 1'b0);
    tick();
    check("stall_idx_a", 64'(oi_a[0]), 64'd3);
    drive(64'h40, 64'd0, 1'b0);
    tick();
    check("stall_idx_b", 64'(oi_a[0]), 64'd3);
    check("stall_pend", pd_a[0], 64'h48);
    drive(64'd0, 64'd0, 1'b0);
    tick();
    check("stall_idx_c", 64'(oi_a[0]), 64'd3);
    drive(64'd0, 64'd0, 1'b1);
    tick();
    check("stall_next", 64'(oi_a[0]), 64'd6);
    tick();
    check("stall_drain", 64'(ov_a[0]), 64'd0);

    // req and clr on the same bit
    drive(64'h08, 64'h08, 1'b0);
    tick();
    check("reqclr_pend", pd_a[0], 64'd0);
    check("reqclr_valid", 64'(ov_a[0]), 64'd0);

    // Re-request of the index being accepted
    drive(64'h08, 64'd0, 1'b0);
    tick();
    drive(64'h08, 64'd0, 1'b1);
    tick();
    check("rereq_pend", pd_a[0], 64'h08);
    check("rereq_idx", 64'(oi_a[0]), 64'd3);
    check("rereq_valid", 64'(ov_a[0]), 64'd1);
    drive(64'd0, 64'd0, 1'b1);
    tick();
    check("rereq_drain", 64'(ov_a[0]), 64'd0);

    // Withdraw of the presented index during a stall
    drive(64'h28, 64'd0, 1'b0);
    tick();
    check("clrp_idx_a", 64'(oi_a[0]), 64'd5);
    drive(64'd0, 64'h20, 1'b0);
    tick();
    check("clrp_idx_b", 64'(oi_a[0]), 64'd3);
    check("clrp_valid_b", 64'(ov_a[0]), 64'd1);
    drive(64'd0, 64'h08, 1'b0);
    tick();
    check("clrp_valid_c", 64'(ov_a[0]), 64'd0);

    // Round-robin with a held request set, including wrap 0 -> 7
    rst = 1'b1;
    drive(64'd0, 64'd0, 1'b0);
    tick();
    rst = 1'b0;
    drive(64'h83, 64'd0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rr_grant%0d", k), 64'(oi_a[1]), 64'(rr_exp[k]));
      if (k == 1) check("fp_held_idx", 64'(oi_a[0]), 64'd7);
    end
    drive(64'd0, 64'd0, 1'b1);
    repeat (4) tick();

    // Random sweep over all configurations
    for (int c = 0; c < NCFG; c++) hold_a[c] = 64'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < NCFG; c++) begin
        if (cyc % 200 == 0) hold_a[c] = {$urandom, $urandom} & {$urandom, $urandom};
        if (cyc % 600 < 200) req_a[c] = hold_a[c];
        else req_a[c] = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        clr_a[c] = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} &
                   {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        ready_a[c] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    rst = 1'b0;
    drive(64'd0, 64'd0, 1'b1);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
